// File: rtl/axi_lite_mux_pkg.sv
// Shared types for the AXI-Lite round-robin mux: FSM state encodings and
// AXI response codes.
package axi_lite_mux_pkg;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ADDR,
    W_RESP
  } wstate_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } rstate_e;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

endpackage

// File: rtl/lite_spill_reg.sv
// Two-entry, non-bypass spill register: one cycle of latency, full
// throughput, and in_ready depends only on internal state.
module lite_spill_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data
);

  logic             a_full_q, a_full_d, b_full_q, b_full_d;
  logic [Width-1:0] a_data_q, a_data_d, b_data_q, b_data_d;

  assign in_ready  = ~b_full_q;
  assign out_valid = a_full_q;
  assign out_data  = a_data_q;

  // Slot a is the head; slot b only fills while a is stalled downstream.
  always_comb begin
    a_full_d = a_full_q;
    b_full_d = b_full_q;
    a_data_d = a_data_q;
    b_data_d = b_data_q;
    if (out_valid && out_ready) begin
      if (b_full_q) begin
        a_data_d = b_data_q;
        b_full_d = 1'b0;
      end else begin
        a_full_d = 1'b0;
      end
    end
    if (in_valid && in_ready) begin
      if (!a_full_d) begin
        a_full_d = 1'b1;
        a_data_d = in_data;
      end else begin
        b_full_d = 1'b1;
        b_data_d = in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_full_q <= 1'b0;
      b_full_q <= 1'b0;
      a_data_q <= '0;
      b_data_q <= '0;
    end else begin
      a_full_q <= a_full_d;
      b_full_q <= b_full_d;
      a_data_q <= a_data_d;
      b_data_q <= b_data_d;
    end
  end

endmodule

// File: rtl/rr_arbiter_lite.sv
// Combinational round-robin pick: first requester at or after ptr_i,
// wrapping, reported as a one-hot grant and a binary index.
module rr_arbiter_lite #(
  parameter int unsigned NumReq = 2,
  parameter int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o
);

  logic            found;
  logic [IdxW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = IdxW'((32'(ptr_i) + i) % NumReq);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/axi_lite_rr_mux.sv
// N:1 AXI-Lite mux with independent round-robin write and read arbitration,
// one outstanding transaction per direction. Define AXI_LITE_MUX_SPILL_EN to
// insert spill registers on master AW, W and AR.
module axi_lite_rr_mux
  import axi_lite_mux_pkg::*;
#(
  parameter int unsigned NumSlvPorts    = 2,
  parameter int unsigned AXI_ADDR_WIDTH = 16,
  parameter int unsigned AXI_DATA_WIDTH = 32
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NumSlvPorts-1:0]                    s_awvalid,
  output logic [NumSlvPorts-1:0]                    s_awready,
  input  logic [NumSlvPorts*AXI_ADDR_WIDTH-1:0]     s_awaddr,
  input  logic [NumSlvPorts-1:0]                    s_wvalid,
  output logic [NumSlvPorts-1:0]                    s_wready,
  input  logic [NumSlvPorts*AXI_DATA_WIDTH-1:0]     s_wdata,
  input  logic [NumSlvPorts*(AXI_DATA_WIDTH/8)-1:0] s_wstrb,
  output logic [NumSlvPorts-1:0]                    s_bvalid,
  input  logic [NumSlvPorts-1:0]                    s_bready,
  output logic [NumSlvPorts*2-1:0]                  s_bresp,
  input  logic [NumSlvPorts-1:0]                    s_arvalid,
  output logic [NumSlvPorts-1:0]                    s_arready,
  input  logic [NumSlvPorts*AXI_ADDR_WIDTH-1:0]     s_araddr,
  output logic [NumSlvPorts-1:0]                    s_rvalid,
  input  logic [NumSlvPorts-1:0]                    s_rready,
  output logic [NumSlvPorts*AXI_DATA_WIDTH-1:0]     s_rdata,
  output logic [NumSlvPorts*2-1:0]                  s_rresp,
  output logic                                      m_awvalid,
  input  logic                                      m_awready,
  output logic [AXI_ADDR_WIDTH-1:0]                 m_awaddr,
  output logic                                      m_wvalid,
  input  logic                                      m_wready,
  output logic [AXI_DATA_WIDTH-1:0]                 m_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]               m_wstrb,
  input  logic                                      m_bvalid,
  output logic                                      m_bready,
  input  logic [1:0]                                m_bresp,
  output logic                                      m_arvalid,
  input  logic                                      m_arready,
  output logic [AXI_ADDR_WIDTH-1:0]                 m_araddr,
  input  logic                                      m_rvalid,
  output logic                                      m_rready,
  input  logic [AXI_DATA_WIDTH-1:0]                 m_rdata,
  input  logic [1:0]                                m_rresp
);

  localparam int unsigned IdxW  = (NumSlvPorts > 1) ? $clog2(NumSlvPorts) : 1;
  localparam int unsigned StrbW = AXI_DATA_WIDTH / 8;

  function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] g);
    if (32'(g) + 1 >= NumSlvPorts) return '0;
    return g + 1'b1;
  endfunction

  wstate_e         wstate_q, wstate_d;
  rstate_e         rstate_q, rstate_d;
  logic [IdxW-1:0] wgnt_q, wgnt_d, wptr_q, wptr_d;
  logic [IdxW-1:0] rgnt_q, rgnt_d, rptr_q, rptr_d;
  logic            aw_done_q, aw_done_d, w_done_q, w_done_d;

  logic [NumSlvPorts-1:0] warb_oh, rarb_oh;
  logic [IdxW-1:0]        warb_idx, rarb_idx;
  int unsigned            wg, rg;

  logic                      aw_fwd_valid, aw_fwd_ready;
  logic                      w_fwd_valid, w_fwd_ready;
  logic                      ar_fwd_valid, ar_fwd_ready;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_sel, ar_addr_sel;
  logic [AXI_DATA_WIDTH-1:0] w_data_sel;
  logic [StrbW-1:0]          w_strb_sel;

  assign wg = 32'(wgnt_q);
  assign rg = 32'(rgnt_q);

  rr_arbiter_lite #(.NumReq(NumSlvPorts), .IdxW(IdxW)) u_warb (
    .req_i(s_awvalid), .ptr_i(wptr_q), .gnt_o(warb_oh), .idx_o(warb_idx)
  );

  rr_arbiter_lite #(.NumReq(NumSlvPorts), .IdxW(IdxW)) u_rarb (
    .req_i(s_arvalid), .ptr_i(rptr_q), .gnt_o(rarb_oh), .idx_o(rarb_idx)
  );

  always_comb begin
    aw_addr_sel = s_awaddr[wg*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
    w_data_sel  = s_wdata[wg*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
    w_strb_sel  = s_wstrb[wg*StrbW +: StrbW];
    ar_addr_sel = s_araddr[rg*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
  end

  // AW and W complete independently; the response phase waits for both.
  always_comb begin
    wstate_d     = wstate_q;
    wgnt_d       = wgnt_q;
    wptr_d       = wptr_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    aw_fwd_valid = 1'b0;
    w_fwd_valid  = 1'b0;
    s_awready    = '0;
    s_wready     = '0;
    s_bvalid     = '0;
    s_bresp      = {NumSlvPorts{RESP_OKAY}};
    m_bready     = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (|warb_oh) begin
          wgnt_d   = warb_idx;
          wstate_d = W_ADDR;
        end
      end
      W_ADDR: begin
        aw_fwd_valid      = s_awvalid[wgnt_q] & ~aw_done_q;
        s_awready[wgnt_q] = aw_fwd_ready & ~aw_done_q;
        w_fwd_valid       = s_wvalid[wgnt_q] & ~w_done_q;
        s_wready[wgnt_q]  = w_fwd_ready & ~w_done_q;
        if (aw_fwd_valid && aw_fwd_ready) aw_done_d = 1'b1;
        if (w_fwd_valid && w_fwd_ready)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) begin
          wstate_d = W_RESP;
          wptr_d   = next_idx(wgnt_q);
        end
      end
      W_RESP: begin
        s_bvalid[wgnt_q]    = m_bvalid;
        m_bready            = s_bready[wgnt_q];
        s_bresp[wg*2 +: 2]  = m_bresp;
        if (m_bvalid && s_bready[wgnt_q]) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          wstate_d  = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_d     = rstate_q;
    rgnt_d       = rgnt_q;
    rptr_d       = rptr_q;
    ar_fwd_valid = 1'b0;
    s_arready    = '0;
    s_rvalid     = '0;
    s_rdata      = '0;
    s_rresp      = {NumSlvPorts{RESP_OKAY}};
    m_rready     = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        if (|rarb_oh) begin
          rgnt_d   = rarb_idx;
          rstate_d = R_ADDR;
        end
      end
      R_ADDR: begin
        ar_fwd_valid      = s_arvalid[rgnt_q];
        s_arready[rgnt_q] = ar_fwd_ready;
        if (ar_fwd_valid && ar_fwd_ready) begin
          rstate_d = R_DATA;
          rptr_d   = next_idx(rgnt_q);
        end
      end
      R_DATA: begin
        s_rvalid[rgnt_q]                             = m_rvalid;
        m_rready                                     = s_rready[rgnt_q];
        s_rdata[rg*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = m_rdata;
        s_rresp[rg*2 +: 2]                           = m_rresp;
        if (m_rvalid && s_rready[rgnt_q]) rstate_d = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
  end

`ifdef AXI_LITE_MUX_SPILL_EN
  // Done flags track the slave-side handshake into the spill register.
  lite_spill_reg #(.Width(AXI_ADDR_WIDTH)) u_aw_spill (
    .clk(clk), .rst(rst),
    .in_valid(aw_fwd_valid), .in_ready(aw_fwd_ready), .in_data(aw_addr_sel),
    .out_valid(m_awvalid), .out_ready(m_awready), .out_data(m_awaddr)
  );

  lite_spill_reg #(.Width(AXI_DATA_WIDTH + StrbW)) u_w_spill (
    .clk(clk), .rst(rst),
    .in_valid(w_fwd_valid), .in_ready(w_fwd_ready), .in_data({w_data_sel, w_strb_sel}),
    .out_valid(m_wvalid), .out_ready(m_wready), .out_data({m_wdata, m_wstrb})
  );

  lite_spill_reg #(.Width(AXI_ADDR_WIDTH)) u_ar_spill (
    .clk(clk), .rst(rst),
    .in_valid(ar_fwd_valid), .in_ready(ar_fwd_ready), .in_data(ar_addr_sel),
    .out_valid(m_arvalid), .out_ready(m_arready), .out_data(m_araddr)
  );
`else
  assign m_awvalid    = aw_fwd_valid;
  assign aw_fwd_ready = m_awready;
  assign m_awaddr     = aw_addr_sel;
  assign m_wvalid     = w_fwd_valid;
  assign w_fwd_ready  = m_wready;
  assign m_wdata      = w_data_sel;
  assign m_wstrb      = w_strb_sel;
  assign m_arvalid    = ar_fwd_valid;
  assign ar_fwd_ready = m_arready;
  assign m_araddr     = ar_addr_sel;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate_q  <= W_IDLE;
      rstate_q  <= R_IDLE;
      wgnt_q    <= '0;
      wptr_q    <= '0;
      rgnt_q    <= '0;
      rptr_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      wstate_q  <= wstate_d;
      rstate_q  <= rstate_d;
      wgnt_q    <= wgnt_d;
      wptr_q    <= wptr_d;
      rgnt_q    <= rgnt_d;
      rptr_q    <= rptr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_rr_mux.sv
// Directed bench for axi_lite_rr_mux: a transaction-level ownership model
// checks every cycle, and per-test literal expectations pin the model.
module tb_axi_lite_rr_mux;

  localparam int N  = 2;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [N-1:0]      s_arvalid, s_arready, s_rvalid, s_rready;
  logic [N*AW-1:0]   s_awaddr, s_araddr;
  logic [N*DW-1:0]   s_wdata, s_rdata;
  logic [N*SW-1:0]   s_wstrb;
  logic [2*N-1:0]    s_bresp, s_rresp;
  logic              m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic              m_arvalid, m_arready, m_rvalid, m_rready;
  logic [AW-1:0]     m_awaddr, m_araddr;
  logic [DW-1:0]     m_wdata, m_rdata;
  logic [SW-1:0]     m_wstrb;
  logic [1:0]        m_bresp, m_rresp;

  always #5 clk = ~clk;

  axi_lite_rr_mux #(.NumSlvPorts(N), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
  );

  typedef struct {
    int         cyc;
    int         port;
    logic [31:0] val;
    logic [3:0]  strb;
    logic [1:0]  resp;
  } ev_t;

  ev_t aw_q[$], w_q[$], ar_q[$], b_q[$], r_q[$];

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model: who owns each direction and which phases have completed.
  int   wown = -1, rown = -1, wptr = 0, rptr = 0;
  bit   aws, ws, ars;
  logic [31:0] last_ctrl;

  // Bench-side slave
  bit         sl_aw, sl_w, hold_b;
  logic [1:0] sl_bresp, sl_rresp;
  logic [31:0] sl_rdata;

  function automatic ev_t mk(int c, int p, logic [31:0] v, logic [3:0] s, logic [1:0] r);
    ev_t e;
    e.cyc = c; e.port = p; e.val = v; e.strb = s; e.resp = r;
    return e;
  endfunction

  function automatic int pick(logic [N-1:0] req, int ptr);
    for (int i = 0; i < N; i++) begin
      int c = (ptr + i) % N;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic compare_cycle();
    logic e_maw, e_mw, e_mb, e_mar, e_mr;
    logic [N-1:0] e_saw, e_sw, e_sb, e_sar, e_sr;
    logic [2*N-1:0] e_bresp, e_rresp;
    logic [N*DW-1:0] e_rdata;
    logic [5*N+4:0] act, ex;
    bit winr;
    {e_maw, e_mw, e_mb, e_mar, e_mr} = '0;
    {e_saw, e_sw, e_sb, e_sar, e_sr} = '0;
    e_bresp = '0; e_rresp = '0; e_rdata = '0;
    winr = (wown >= 0) && aws && ws;
    if (wown >= 0 && !winr) begin
      if (!aws) begin e_maw = s_awvalid[wown]; e_saw[wown] = m_awready; end
      if (!ws)  begin e_mw  = s_wvalid[wown];  e_sw[wown]  = m_wready;  end
    end
    if (winr) begin
      e_sb[wown] = m_bvalid;
      e_mb = s_bready[wown];
      e_bresp[2*wown +: 2] = m_bresp;
    end
    if (rown >= 0 && !ars) begin e_mar = s_arvalid[rown]; e_sar[rown] = m_arready; end
    if (rown >= 0 && ars) begin
      e_sr[rown] = m_rvalid;
      e_mr = s_rready[rown];
      e_rdata[DW*rown +: DW] = m_rdata;
      e_rresp[2*rown +: 2] = m_rresp;
    end
    act = {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready,
           s_awready, s_wready, s_bvalid, s_arready, s_rvalid};
    ex  = {e_maw, e_mw, e_mb, e_mar, e_mr, e_saw, e_sw, e_sb, e_sar, e_sr};
    last_ctrl = 32'(act);
    chk("ctrl", 128'(act), 128'(ex));
    chk("s_bresp", 128'(s_bresp), 128'(e_bresp));
    chk("s_rresp", 128'(s_rresp), 128'(e_rresp));
    chk("s_rdata", 128'(s_rdata), 128'(e_rdata));
    if (e_maw) chk("m_awaddr", 128'(m_awaddr), 128'(s_awaddr[AW*wown +: AW]));
    if (e_mw)  chk("m_w", 128'({m_wdata, m_wstrb}), 128'({s_wdata[DW*wown +: DW], s_wstrb[SW*wown +: SW]}));
    if (e_mar) chk("m_araddr", 128'(m_araddr), 128'(s_araddr[AW*rown +: AW]));

    if (m_awvalid && m_awready) aw_q.push_back(mk(cyc, -1, 32'(m_awaddr), 4'h0, 2'b00));
    if (m_wvalid && m_wready)   w_q.push_back(mk(cyc, -1, m_wdata, m_wstrb, 2'b00));
    if (m_arvalid && m_arready) ar_q.push_back(mk(cyc, -1, 32'(m_araddr), 4'h0, 2'b00));
    for (int p = 0; p < N; p++) begin
      if (s_bvalid[p] && s_bready[p]) b_q.push_back(mk(cyc, p, 32'h0, 4'h0, s_bresp[2*p +: 2]));
      if (s_rvalid[p] && s_rready[p]) r_q.push_back(mk(cyc, p, s_rdata[DW*p +: DW], 4'h0, s_rresp[2*p +: 2]));
    end

    if (rst) begin
      wown = -1; aws = 0; ws = 0; wptr = 0;
      rown = -1; ars = 0; rptr = 0;
    end else begin
      if (wown < 0) wown = pick(s_awvalid, wptr);
      else if (!winr) begin
        if (e_maw && m_awready) aws = 1;
        if (e_mw && m_wready)   ws  = 1;
        if (aws && ws) wptr = (wown + 1) % N;
      end else if (m_bvalid && s_bready[wown]) begin
        wown = -1; aws = 0; ws = 0;
      end
      if (rown < 0) rown = pick(s_arvalid, rptr);
      else if (!ars) begin
        if (e_mar && m_arready) begin ars = 1; rptr = (rown + 1) % N; end
      end else if (m_rvalid && s_rready[rown]) begin
        rown = -1; ars = 0;
      end
    end
    cyc++;
  endtask

  task automatic step();
    logic [N-1:0] awh, wh, arh;
    logic maw, mw, mb, mar, mr;
    @(negedge clk);
    compare_cycle();
    awh = s_awvalid & s_awready;
    wh  = s_wvalid & s_wready;
    arh = s_arvalid & s_arready;
    maw = m_awvalid & m_awready;
    mw  = m_wvalid & m_wready;
    mb  = m_bvalid & m_bready;
    mar = m_arvalid & m_arready;
    mr  = m_rvalid & m_rready;
    @(posedge clk);
    #1;
    s_awvalid = s_awvalid & ~awh;
    s_wvalid  = s_wvalid & ~wh;
    s_arvalid = s_arvalid & ~arh;
    if (rst) begin
      sl_aw = 0; sl_w = 0; m_bvalid = 1'b0; m_rvalid = 1'b0;
    end else begin
      if (mb) m_bvalid = 1'b0;
      if (mr) m_rvalid = 1'b0;
      if (maw) sl_aw = 1;
      if (mw)  sl_w  = 1;
      if (sl_aw && sl_w && !hold_b && !m_bvalid) begin
        m_bvalid = 1'b1; m_bresp = sl_bresp; sl_aw = 0; sl_w = 0;
      end
      if (mar) begin m_rvalid = 1'b1; m_rdata = sl_rdata; m_rresp = sl_rresp; end
    end
  endtask

  task automatic issue_w(int p, logic [AW-1:0] a, logic [DW-1:0] d, logic [SW-1:0] s);
    s_awvalid[p] = 1'b1;
    s_awaddr[p*AW +: AW] = a;
    s_wvalid[p] = 1'b1;
    s_wdata[p*DW +: DW] = d;
    s_wstrb[p*SW +: SW] = s;
  endtask

  task automatic issue_r(int p, logic [AW-1:0] a);
    s_arvalid[p] = 1'b1;
    s_araddr[p*AW +: AW] = a;
  endtask

  task automatic wait_b(int n, int budget);
    for (int i = 0; i < budget && b_q.size() < n; i++) step();
    chk("wait_b", 128'(b_q.size()), 128'(n));
  endtask

  task automatic wait_r(int n, int budget);
    for (int i = 0; i < budget && r_q.size() < n; i++) step();
    chk("wait_r", 128'(r_q.size()), 128'(n));
  endtask

  task automatic clear_logs();
    aw_q.delete(); w_q.delete(); ar_q.delete(); b_q.delete(); r_q.delete();
  endtask

  initial begin
    int t0;
    rst = 1'b1;
    s_awvalid = '0; s_wvalid = '0; s_arvalid = '0;
    s_awaddr = '0; s_araddr = '0; s_wdata = '0; s_wstrb = '0;
    s_bready = '1; s_rready = '1;
    m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
    m_bvalid = 1'b0; m_bresp = 2'b00; m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00;
    hold_b = 0; sl_aw = 0; sl_w = 0; sl_bresp = 2'b00; sl_rresp = 2'b00; sl_rdata = '0;
    repeat (3) step();
    chk("reset_ctrl", 128'(last_ctrl), 128'(0));
    rst = 1'b0;
    step();

    // Single write from port 1
    clear_logs();
    t0 = cyc;
    issue_w(1, 16'h0010, 32'hDEADBEEF, 4'hF);
    wait_b(1, 20);
    chk("t1_aw_latency", 128'(aw_q[0].cyc - t0), 128'(1));
    chk("t1_awaddr", 128'(aw_q[0].val), 128'(32'h0010));
    chk("t1_wdata", 128'(w_q[0].val), 128'(32'hDEADBEEF));
    chk("t1_wstrb", 128'(w_q[0].strb), 128'(4'hF));
    chk("t1_b_port", 128'(b_q[0].port), 128'(1));
    chk("t1_b_resp", 128'(b_q[0].resp), 128'(2'b00));

    // Simultaneous requests, then port 0 re-requests while port 1 waits
    clear_logs();
    issue_w(0, 16'h0100, 32'h11111111, 4'hF);
    issue_w(1, 16'h0104, 32'h22222222, 4'h3);
    wait_b(1, 20);
    issue_w(0, 16'h0108, 32'h33333333, 4'hC);
    wait_b(3, 40);
    chk("t2_order0", 128'(b_q[0].port), 128'(0));
    chk("t2_order1", 128'(b_q[1].port), 128'(1));
    chk("t2_order2", 128'(b_q[2].port), 128'(0));
    chk("t2_w1", 128'({w_q[1].val, w_q[1].strb}), 128'({32'h22222222, 4'h3}));
    chk("t2_aw2", 128'(aw_q[2].val), 128'(32'h0108));

    // W leads AW by three cycles
    clear_logs();
    s_wvalid[0] = 1'b1;
    s_wdata[0 +: DW] = 32'hCAFEF00D;
    s_wstrb[0 +: SW] = 4'hF;
    s_awaddr[0 +: AW] = 16'h0050;
    repeat (3) step();
    chk("t3_no_early_w", 128'(w_q.size()), 128'(0));
    s_awvalid[0] = 1'b1;
    wait_b(1, 20);
    repeat (2) step();
    chk("t3_w_beats", 128'(w_q.size()), 128'(1));
    chk("t3_wdata", 128'(w_q[0].val), 128'(32'hCAFEF00D));
    chk("t3_b_port", 128'(b_q[0].port), 128'(0));

    // Concurrent write (port 0) and read (port 1)
    clear_logs();
    sl_rdata = 32'h12345678;
    issue_w(0, 16'h0200, 32'h0BADF00D, 4'hF);
    issue_r(1, 16'h0020);
    wait_b(1, 20);
    wait_r(1, 20);
    chk("t4_araddr", 128'(ar_q[0].val), 128'(32'h0020));
    chk("t4_overlap", 128'(ar_q[0].cyc), 128'(aw_q[0].cyc));
    chk("t4_r_port", 128'(r_q[0].port), 128'(1));
    chk("t4_rdata", 128'(r_q[0].val), 128'(32'h12345678));

    // Error responses pass through unchanged
    clear_logs();
    sl_bresp = 2'b10;
    sl_rresp = 2'b11;
    sl_rdata = 32'hA5A5A5A5;
    issue_w(1, 16'h0300, 32'h55555555, 4'hF);
    issue_r(0, 16'h0040);
    wait_b(1, 20);
    wait_r(1, 20);
    chk("t5_b_port", 128'(b_q[0].port), 128'(1));
    chk("t5_slverr", 128'(b_q[0].resp), 128'(2'b10));
    chk("t5_r_port", 128'(r_q[0].port), 128'(0));
    chk("t5_decerr", 128'(r_q[0].resp), 128'(2'b11));
    chk("t5_rdata", 128'(r_q[0].val), 128'(32'hA5A5A5A5));
    sl_bresp = 2'b00;
    sl_rresp = 2'b00;

    // Reset while a write waits for its response
    clear_logs();
    hold_b = 1;
    issue_w(0, 16'h0400, 32'h44444444, 4'hF);
    for (int i = 0; i < 20 && aw_q.size() < 1; i++) step();
    chk("t6_aw_sent", 128'(aw_q.size()), 128'(1));
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    hold_b = 0;
    s_awvalid = '0; s_wvalid = '0; s_arvalid = '0;
    step();
    chk("t6_post_reset_ctrl", 128'(last_ctrl), 128'(0));
    repeat (3) step();
    chk("t6_no_completion", 128'(b_q.size()), 128'(0));
    issue_w(0, 16'h0500, 32'h66666666, 4'hF);
    issue_w(1, 16'h0504, 32'h77777777, 4'hF);
    wait_b(2, 40);
    chk("t6_first_port", 128'(b_q[0].port), 128'(0));
    chk("t6_second_port", 128'(b_q[1].port), 128'(1));

    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
